// File: rtl/verdict_monitor.sv
// Host-side checker for the anomaly-detector verdict stream: classifies UART bytes,
// tracks outstanding samples, counts outcomes and flags timeouts and anomaly runs.
module verdict_monitor #(
    parameter int ALARM_RUN = 3,
    parameter int TIMEOUT   = 20000,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             sample_sent,
    input  logic             clr,
    output logic             verdict_valid,
    output logic             verdict_anom,
    output logic             verdict_err,
    output logic [CNT_W-1:0] normal_cnt,
    output logic [CNT_W-1:0] anomaly_cnt,
    output logic [CNT_W-1:0] error_cnt,
    output logic [7:0]       run_len,
    output logic [3:0]       pending,
    output logic             alarm,
    output logic             timeout_flag
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state_reg, state_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic [3:0]       pending_reg, pending_next;
    logic [7:0]       run_len_reg, run_len_next;
    logic             alarm_reg, timeout_flag_reg;
    logic             verdict_valid_reg, verdict_anom_reg, verdict_err_reg;
    logic [CNT_W-1:0] cnt_reg [3];
    logic [2:0]       cnt_inc;

    logic consume, unsol, is_norm, is_anom, expire, overflow;

    always_comb begin
        consume  = rx_valid && (pending_reg != 4'd0);
        unsol    = rx_valid && (pending_reg == 4'd0);
        is_norm  = (rx_data == 8'h01);
        is_anom  = (rx_data == 8'hFF);
        // Any strobe restarts the timer, so expiry only fires on a fully quiet cycle.
        expire   = (state_reg == WAIT) && (timer_reg == TMR_LAST) && !rx_valid && !sample_sent;
        overflow = sample_sent && !consume && (pending_reg == 4'hF);

        pending_next = pending_reg;
        if (expire)
            pending_next = 4'd0;
        else if (sample_sent && !consume && pending_reg != 4'hF)
            pending_next = pending_reg + 4'd1;
        else if (!sample_sent && consume)
            pending_next = pending_reg - 4'd1;

        timer_next = '0;
        if (state_reg == WAIT && !rx_valid && !sample_sent && !expire)
            timer_next = timer_reg + TMR_W'(1);

        state_next = (pending_next != 4'd0) ? WAIT : IDLE;

        run_len_next = run_len_reg;
        if (consume) begin
            if (is_anom)
                run_len_next = (run_len_reg == 8'hFF) ? 8'hFF : run_len_reg + 8'd1;
            else
                run_len_next = 8'd0;
        end

        cnt_inc[0] = consume && is_norm;
        cnt_inc[1] = consume && is_anom;
        cnt_inc[2] = unsol || (consume && !is_norm && !is_anom) || expire || overflow;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= IDLE;
            timer_reg         <= '0;
            pending_reg       <= 4'd0;
            run_len_reg       <= 8'd0;
            alarm_reg         <= 1'b0;
            timeout_flag_reg  <= 1'b0;
            verdict_valid_reg <= 1'b0;
            verdict_anom_reg  <= 1'b0;
            verdict_err_reg   <= 1'b0;
        end else begin
            state_reg         <= state_next;
            timer_reg         <= timer_next;
            pending_reg       <= pending_next;
            verdict_valid_reg <= rx_valid;
            verdict_anom_reg  <= consume && is_anom;
            verdict_err_reg   <= unsol || (consume && !is_norm && !is_anom);
            if (clr) begin
                run_len_reg      <= 8'd0;
                alarm_reg        <= 1'b0;
                timeout_flag_reg <= 1'b0;
            end else begin
                run_len_reg      <= run_len_next;
                alarm_reg        <= alarm_reg || (run_len_next >= 8'(ALARM_RUN));
                timeout_flag_reg <= timeout_flag_reg || expire;
            end
        end
    end

    // Statistics counters: 0 = normal, 1 = anomaly, 2 = error; all saturate.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    cnt_reg[gi] <= '0;
                else if (clr)
                    cnt_reg[gi] <= '0;
                else if (cnt_inc[gi] && cnt_reg[gi] != {CNT_W{1'b1}})
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
            end
        end
    endgenerate

    assign verdict_valid = verdict_valid_reg;
    assign verdict_anom  = verdict_anom_reg;
    assign verdict_err   = verdict_err_reg;
    assign normal_cnt    = cnt_reg[0];
    assign anomaly_cnt   = cnt_reg[1];
    assign error_cnt     = cnt_reg[2];
    assign run_len       = run_len_reg;
    assign pending       = pending_reg;
    assign alarm         = alarm_reg;
    assign timeout_flag  = timeout_flag_reg;

endmodule

// File: tb/tb_verdict_monitor.sv
// Directed bench for verdict_monitor (ALARM_RUN=3, TIMEOUT=50, narrow counters so
// saturation is reachable in a handful of bytes).
module tb_verdict_monitor;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_valid = 1'b0;
    logic             sample_sent = 1'b0;
    logic             clr = 1'b0;
    logic             verdict_valid, verdict_anom, verdict_err;
    logic [CNT_W-1:0] normal_cnt, anomaly_cnt, error_cnt;
    logic [7:0]       run_len;
    logic [3:0]       pending;
    logic             alarm, timeout_flag;

    int n_cmp = 0;
    int n_err = 0;

    verdict_monitor #(.ALARM_RUN(3), .TIMEOUT(50), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .sample_sent(sample_sent), .clr(clr),
        .verdict_valid(verdict_valid), .verdict_anom(verdict_anom), .verdict_err(verdict_err),
        .normal_cnt(normal_cnt), .anomaly_cnt(anomaly_cnt), .error_cnt(error_cnt),
        .run_len(run_len), .pending(pending), .alarm(alarm), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_sample();
        sample_sent = 1'b1;
        tick();
        sample_sent = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        $display("rx %02h -> valid=%0b anom=%0b err=%0b pending=%0d run=%0d", b,
                 verdict_valid, verdict_anom, verdict_err, pending, run_len);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("reset_outputs", {verdict_valid, verdict_anom, verdict_err, normal_cnt, anomaly_cnt,
                              error_cnt, run_len, pending, alarm, timeout_flag}, 32'd0);
        rst = 1'b1;
        tick();

        // Normal round trip
        repeat (3) send_sample();
        chk("rt_pending3", pending, 3);
        send_byte(8'h01);
        chk("rt_valid", verdict_valid, 1);
        chk("rt_anom0", verdict_anom, 0);
        chk("rt_pending2", pending, 2);
        send_byte(8'hFF);
        chk("rt_anom1", verdict_anom, 1);
        chk("rt_run1", run_len, 1);
        send_byte(8'h01);
        chk("rt_run0", run_len, 0);
        chk("rt_pending0", pending, 0);
        chk("rt_normal", normal_cnt, 2);
        chk("rt_anomaly", anomaly_cnt, 1);
        chk("rt_alarm", alarm, 0);
        tick();
        chk("rt_pulse_end", verdict_valid, 0);

        // Alarm
        do_clr();
        repeat (4) send_sample();
        send_byte(8'hFF);
        send_byte(8'hFF);
        chk("al_run2", run_len, 2);
        chk("al_not_yet", alarm, 0);
        send_byte(8'hFF);
        chk("al_run3", run_len, 3);
        chk("al_set", alarm, 1);
        send_byte(8'h01);
        chk("al_run_reset", run_len, 0);
        chk("al_sticky", alarm, 1);
        chk("al_pending0", pending, 0);
        do_clr();
        chk("al_clr", alarm, 0);
        chk("al_clr_anom", anomaly_cnt, 0);

        // Protocol errors
        repeat (2) send_sample();
        send_byte(8'hFF);
        chk("pe_run1", run_len, 1);
        send_byte(8'h37);
        chk("pe_bad_err", verdict_err, 1);
        chk("pe_bad_cnt", error_cnt, 1);
        chk("pe_bad_pending", pending, 0);
        chk("pe_bad_run", run_len, 0);
        send_byte(8'h01);
        chk("pe_unsol_err", verdict_err, 1);
        chk("pe_unsol_cnt", error_cnt, 2);
        chk("pe_unsol_normal", normal_cnt, 0);
        chk("pe_unsol_pending", pending, 0);

        // Timeout
        do_clr();
        repeat (2) send_sample();
        repeat (49) tick();
        chk("to_early_flag", timeout_flag, 0);
        chk("to_early_pending", pending, 2);
        tick();
        chk("to_flag", timeout_flag, 1);
        chk("to_pending", pending, 0);
        chk("to_err", error_cnt, 1);

        // Byte in the expiry cycle suppresses the timeout
        do_clr();
        repeat (2) send_sample();
        repeat (49) tick();
        send_byte(8'hFF);
        chk("ts_anom", anomaly_cnt, 1);
        chk("ts_pending", pending, 1);
        chk("ts_flag", timeout_flag, 0);
        chk("ts_err", error_cnt, 0);
        send_byte(8'h01);
        tick();
        chk("ts_flag_after", timeout_flag, 0);

        // Pending overflow
        do_clr();
        repeat (15) send_sample();
        chk("ov_pending15", pending, 15);
        chk("ov_err0", error_cnt, 0);
        send_sample();
        chk("ov_pending_sat", pending, 15);
        chk("ov_err1", error_cnt, 1);
        repeat (50) tick();
        chk("ov_drain", pending, 0);

        // Simultaneous sample and byte
        do_clr();
        repeat (2) send_sample();
        sample_sent = 1'b1;
        send_byte(8'hFF);
        sample_sent = 1'b0;
        chk("sim_pending", pending, 2);
        chk("sim_anom", anomaly_cnt, 1);
        send_byte(8'h01);
        send_byte(8'h01);
        chk("sim_drained", pending, 0);
        sample_sent = 1'b1;
        send_byte(8'h01);
        sample_sent = 1'b0;
        chk("sim_unsol_err", verdict_err, 1);
        chk("sim_unsol_cnt", error_cnt, 1);
        chk("sim_unsol_pending", pending, 1);
        chk("sim_unsol_normal", normal_cnt, 2);
        send_byte(8'h01);

        // Counter saturation
        do_clr();
        for (int i = 0; i < 20; i++) send_byte(8'h55);
        chk("sat_err", error_cnt, 15);

        // Reset mid-operation
        do_clr();
        repeat (6) send_sample();
        repeat (3) send_byte(8'hFF);
        chk("rm_alarm", alarm, 1);
        chk("rm_pending", pending, 3);
        rst = 1'b0;
        #1;
        chk("rm_async_zero", {verdict_valid, verdict_anom, verdict_err, normal_cnt, anomaly_cnt,
                              error_cnt, run_len, pending, alarm, timeout_flag}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        send_sample();
        send_byte(8'h01);
        chk("rm_resume_normal", normal_cnt, 1);
        chk("rm_resume_anom", anomaly_cnt, 0);
        chk("rm_resume_pending", pending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
